// File: rtl/exe_muldiv_if.sv
// EXE-stage handshake between the pipeline and the iterative mul/div sequencer.
// The sequencer takes the slave modport; the pipeline (or a bench) drives the master side.
interface exe_muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [1:0]            op_i;
    logic [DATA_WIDTH-1:0] op1_i;
    logic [DATA_WIDTH-1:0] op2_i;
    logic                  flush_i;
    logic                  busy_o;
    logic                  stall_o;
    logic                  valid_o;
    logic [DATA_WIDTH-1:0] result_o;

    modport slave (
        input  start_i, op_i, op1_i, op2_i, flush_i,
        output busy_o, stall_o, valid_o, result_o
    );

    modport master (
        output start_i, op_i, op1_i, op2_i, flush_i,
        input  busy_o, stall_o, valid_o, result_o
    );
endinterface

// File: rtl/exe_muldiv_ctrl.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer beside the EXE ALU: one bit per cycle,
// stalls the front of the pipe until the registered result is shown for a single DONE cycle.
module exe_muldiv_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    exe_muldiv_if.slave  bus
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [1:0]            op_q;
    // a_q is acc (mul) or rem (div); its extra top bit is always zero between steps, so only DW bits are kept.
    logic [DW-1:0]         a_q;
    logic [DW-1:0]         b_q;      // mq (mul) or quo (div)
    logic [DW-1:0]         opnd_q;   // multiplicand or divisor
    logic                  busy_q;
    logic                  valid_q;
    logic [DW-1:0]         result_q;

    logic [DW:0]           mul_sum;
    logic [DW:0]           rem_sh;
    logic [DW:0]           trial;
    logic                  div_ok;
    logic [DW-1:0]         step_a_d;
    logic [DW-1:0]         step_b_d;
    logic [DW-1:0]         res_d;
    logic                  div_by_zero;

    always_comb begin
        mul_sum  = {1'b0, a_q} + (b_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {a_q, b_q[DW-1]};
        trial    = rem_sh - {1'b0, opnd_q};
        div_ok   = ~trial[DW];
        step_a_d = mul_sum[DW:1];
        step_b_d = {mul_sum[0], b_q[DW-1:1]};
        if (op_q[1]) begin
            step_a_d = div_ok ? trial[DW-1:0] : rem_sh[DW-1:0];
            step_b_d = {b_q[DW-2:0], div_ok};
        end
        // MULHU/REMU take the upper/remainder half, MUL/DIVU the lower/quotient half.
        res_d = op_q[0] ? step_a_d : step_b_d;
    end

    assign div_by_zero = bus.op_i[1] & (bus.op2_i == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        op_q   <= bus.op_i;
                        cnt_q  <= CNT_WIDTH'(DW - 1);
                        busy_q <= 1'b1;
                        if (div_by_zero) begin
                            state_q  <= S_DONE;
                            valid_q  <= 1'b1;
                            result_q <= bus.op_i[0] ? bus.op1_i : '1;
                        end else begin
                            state_q <= S_RUN;
                            a_q     <= '0;
                            b_q     <= bus.op_i[1] ? bus.op1_i : bus.op2_i;
                            opnd_q  <= bus.op_i[1] ? bus.op2_i : bus.op1_i;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.flush_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        a_q   <= step_a_d;
                        b_q   <= step_b_d;
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                        if (cnt_q == '0) begin
                            state_q  <= S_DONE;
                            valid_q  <= 1'b1;
                            result_q <= res_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Low in DONE so the stalled stage advances and captures result_o that cycle.
    assign bus.stall_o  = bus.start_i & ~valid_q & ~bus.flush_i;
    assign bus.busy_o   = busy_q;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Randomized + directed bench for exe_muldiv_ctrl against an arithmetic reference model.
module tb_exe_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   pulse_cyc = 0;
    logic [31:0] last_res = '0;

    exe_muldiv_if #(.DATA_WIDTH(32)) bus ();

    exe_muldiv_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Entered #1 after a rising edge with the DUT idle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, input bit keep);
        int n;
        int lat;
        bit stall_ok;
        logic [31:0] exp;
        exp = ref_res(op, a, b);
        lat = (op[1] && b == 0) ? 1 : 33;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.op1_i   = a;
        bus.op2_i   = b;
        #1;
        chk("stall_first", 32'(bus.stall_o), 32'd1);
        n = 0;
        stall_ok = 1'b1;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (bus.valid_o) break;
            if (bus.stall_o !== 1'b1 || bus.busy_o !== 1'b1) stall_ok = 1'b0;
            if (scramble) begin
                bus.op_i  = 2'($urandom);
                bus.op1_i = $urandom;
                bus.op2_i = $urandom;
            end
        end
        pulse_cyc = cyc;
        chk("latency", 32'(n), 32'(lat));
        chk("result", bus.result_o, exp);
        chk("stall_run", 32'(stall_ok), 32'd1);
        chk("stall_done", 32'(bus.stall_o), 32'd0);
        chk("busy_done", 32'(bus.busy_o), 32'd1);
        last_res = exp;
        if (!keep) bus.start_i = 1'b0;
        @(posedge clk); #1;
        chk("valid_pulse", 32'(bus.valid_o), 32'd0);
        chk("busy_idle", 32'(bus.busy_o), 32'd0);
    endtask

    logic [1:0]  d_op [10] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1};
    logic [31:0] d_a  [10] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd5, 32'd5,
                               32'h1234_5678, 32'h1234_5678, 32'h8000_0000};
    logic [31:0] d_b  [10] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd9, 32'd9,
                               32'd0, 32'd0, 32'd2};

    initial begin
        int c1;
        bit seen;
        logic [31:0] a, b;
        logic [1:0] op;
        bus.start_i = 1'b0;
        bus.op_i    = '0;
        bus.op1_i   = '0;
        bus.op2_i   = '0;
        bus.flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);

        for (int i = 0; i < 10; i++) run_op(d_op[i], d_a[i], d_b[i], 1'b0, 1'b0);

        // Back-to-back with start held and operands wiggled mid-run.
        run_op(2'd2, 32'hDEAD_BEEF, 32'd1234, 1'b1, 1'b1);
        c1 = pulse_cyc;
        run_op(2'd0, 32'h0001_2345, 32'h0000_6789, 1'b1, 1'b0);
        chk("b2b_gap", 32'(pulse_cyc - c1), 32'd34);

        // Flush mid-run.
        bus.start_i = 1'b1; bus.op_i = 2'd0; bus.op1_i = 32'd11; bus.op2_i = 32'd13;
        repeat (10) @(posedge clk);
        #1 bus.flush_i = 1'b1;
        #1 chk("flush_stall", 32'(bus.stall_o), 32'd0);
        @(posedge clk); #1;
        bus.flush_i = 1'b0; bus.start_i = 1'b0;
        chk("flush_busy", 32'(bus.busy_o), 32'd0);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bus.valid_o) seen = 1'b1; end
        chk("flush_novalid", 32'(seen), 32'd0);
        chk("flush_result", bus.result_o, last_res);

        // Reset mid-run.
        bus.start_i = 1'b1; bus.op_i = 2'd1; bus.op1_i = 32'hFFFF_0000; bus.op2_i = 32'h1234_0000;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1; bus.flush_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.flush_i = 1'b0; bus.start_i = 1'b0;
        chk("rstmid_result", bus.result_o, 32'd0);
        chk("rstmid_busy", 32'(bus.busy_o), 32'd0);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bus.valid_o) seen = 1'b1; end
        chk("rstmid_novalid", 32'(seen), 32'd0);

        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom);
            case ($urandom_range(0, 3))
                0:       begin a = $urandom; b = 32'd0; end
                1:       begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op(op, a, b, 1'($urandom), (i < 29) ? 1'($urandom) : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
